// File: rtl/uart_boot_pkg.sv
// Shared types and constant prompt texts for the UART boot loader.
// Messages are ASCII, space-padded, and always end in a line feed.
package uart_boot_pkg;

    typedef enum logic [2:0] {
        S_SEND_INIT,
        S_RECV_SIZE,
        S_ECHO_SIZE,
        S_RECV_DATA,
        S_SEND_DONE,
        S_RECV_ADDR,
        S_FINISH
    } boot_state_t;

    typedef enum logic [1:0] {
        MSG_INIT,
        MSG_DONE,
        MSG_ECHO
    } msg_sel_t;

    localparam int INIT_MSG_LEN = 40;
    localparam int DONE_MSG_LEN = 57;
    localparam int ECHO_LEN     = 4;

    localparam int INIT_TXT_LEN = 15;
    localparam int DONE_TXT_LEN = 20;
    localparam logic [0:INIT_TXT_LEN-1][7:0] INIT_TXT = "BOOT: SEND SIZE";
    localparam logic [0:DONE_TXT_LEN-1][7:0] DONE_TXT = "DONE: SEND NEXT ADDR";

    typedef logic [0:INIT_MSG_LEN-1][7:0] init_msg_t;
    typedef logic [0:DONE_MSG_LEN-1][7:0] done_msg_t;

    function automatic init_msg_t build_init_msg();
        init_msg_t m;
        for (int i = 0; i < INIT_MSG_LEN; i++) begin
            if (i == INIT_MSG_LEN - 1)  m[i] = 8'h0A;
            else if (i < INIT_TXT_LEN)  m[i] = INIT_TXT[i];
            else                        m[i] = 8'h20;
        end
        return m;
    endfunction

    function automatic done_msg_t build_done_msg();
        done_msg_t m;
        for (int i = 0; i < DONE_MSG_LEN; i++) begin
            if (i == DONE_MSG_LEN - 1)  m[i] = 8'h0A;
            else if (i < DONE_TXT_LEN)  m[i] = DONE_TXT[i];
            else                        m[i] = 8'h20;
        end
        return m;
    endfunction

    localparam init_msg_t INIT_MSG = build_init_msg();
    localparam done_msg_t DONE_MSG = build_done_msg();

    function automatic logic [5:0] msg_last_idx(input logic [1:0] sel);
        case (sel)
            MSG_INIT: return 6'(INIT_MSG_LEN - 1);
            MSG_DONE: return 6'(DONE_MSG_LEN - 1);
            default:  return 6'(ECHO_LEN - 1);
        endcase
    endfunction

    // The echo source is sent most significant byte first.
    function automatic logic [7:0] msg_byte(input logic [1:0] sel, input logic [5:0] idx,
                                            input logic [31:0] echo);
        case (sel)
            MSG_INIT: return INIT_MSG[idx];
            MSG_DONE: return DONE_MSG[idx];
            default: begin
                case (idx[1:0])
                    2'd0:    return echo[31:24];
                    2'd1:    return echo[23:16];
                    2'd2:    return echo[15:8];
                    default: return echo[7:0];
                endcase
            end
        endcase
    endfunction

endpackage

// File: rtl/uart_boot_msg_sender.sv
// Streams one selected message to uart_tx while enabled, honouring tx_busy_i
// plus a one-cycle guard so a late busy rise never causes a double send.
module uart_boot_msg_sender
    import uart_boot_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [1:0]  sel_i,
    input  logic [31:0] echo_i,
    input  logic        tx_busy_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    output logic        done_o
);

    logic [5:0] idx_q, idx_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_valid_q;
    logic       fire;
    logic       last;

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        fire      = en_i && !tx_busy_i && !tx_valid_q;
        last      = (idx_q == msg_last_idx(sel_i));
        idx_d     = idx_q;
        tx_data_d = tx_data_q;
        if (fire) begin
            tx_data_d = msg_byte(sel_i, idx_q, echo_i);
            idx_d     = last ? 6'd0 : idx_q + 6'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update
    // together from values sampled before the edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= fire;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
    assign done_o     = fire && last;

endmodule

// File: rtl/uart_boot_loader.sv
// Device-side UART boot loader: prompts the host, receives sized payloads
// into memory region by region, and releases the core on a zero address.
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    input  logic              tx_busy_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              core_rst_o,
    output logic              boot_done_o
);

    boot_state_t       state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       remaining_q, remaining_d;
    logic [ADDR_W-1:0] region_q, region_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              send_en;
    msg_sel_t          msg_sel;
    logic              send_done;
    logic [31:0]       shift_in;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        remaining_d = remaining_q;
        region_d    = region_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        send_en     = 1'b0;
        msg_sel     = MSG_INIT;
        shift_in    = {shift_q[23:0], rx_data_i};

        case (state_q)
            S_SEND_INIT: begin
                send_en = 1'b1;
                if (send_done) state_d = S_RECV_SIZE;
            end
            S_RECV_SIZE: begin
                if (rx_valid_i) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = S_ECHO_SIZE;
                end
            end
            // shift_q holds the received size until the payload starts.
            S_ECHO_SIZE: begin
                send_en = 1'b1;
                msg_sel = MSG_ECHO;
                if (send_done) begin
                    if (shift_q == 32'd0) begin
                        state_d = S_SEND_DONE;
                    end else begin
                        remaining_d = shift_q;
                        state_d     = S_RECV_DATA;
                    end
                end
            end
            // Payload arrives last byte first, so the k-th byte lands at
            // region + remaining - 1.
            S_RECV_DATA: begin
                if (rx_valid_i) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = region_q + ADDR_W'(remaining_q - 32'd1);
                    mem_wdata_d = rx_data_i;
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) state_d = S_SEND_DONE;
                end
            end
            S_SEND_DONE: begin
                send_en = 1'b1;
                msg_sel = MSG_DONE;
                if (send_done) state_d = S_RECV_ADDR;
            end
            S_RECV_ADDR: begin
                if (rx_valid_i) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (shift_in == 32'd0) begin
                            state_d = S_FINISH;
                        end else begin
                            region_d = ADDR_W'(shift_in);
                            state_d  = S_SEND_INIT;
                        end
                    end
                end
            end
            S_FINISH: ;
            default: state_d = S_SEND_INIT;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_SEND_INIT;
            cnt_q       <= '0;
            shift_q     <= '0;
            remaining_q <= '0;
            region_q    <= START_ADDR;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            remaining_q <= remaining_d;
            region_q    <= region_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    uart_boot_msg_sender u_sender (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .en_i       (send_en),
        .sel_i      (msg_sel),
        .echo_i     (shift_q),
        .tx_busy_i  (tx_busy_i),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .done_o     (send_done)
    );

    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign core_rst_o  = (state_q != S_FINISH);
    assign boot_done_o = (state_q == S_FINISH);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: a host model drives the protocol,
// a uart_tx model produces busy, and captured traffic is compared to expectations.
module tb_uart_boot_loader;

    localparam int          ADDR_W     = 32;
    localparam logic [31:0] START_ADDR = 32'h0000_0000;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [7:0]        rx_data_i = '0;
    logic              rx_valid_i = 1'b0;
    logic              tx_busy_i = 1'b0;
    logic [7:0]        tx_data_o;
    logic              tx_valid_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic              core_rst_o;
    logic              boot_done_o;

    uart_boot_loader #(.ADDR_W(ADDR_W), .START_ADDR(START_ADDR)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .tx_busy_i   (tx_busy_i),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .core_rst_o  (core_rst_o),
        .boot_done_o (boot_done_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] tx_q[$];
    logic [39:0] wr_q[$];
    int         proto_viol = 0;
    int         busy_cnt   = 0;
    bit         force_busy = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_we    = 1'b0;

    // uart_tx stand-in: busy sometimes rises a cycle late (busy_cnt == 0),
    // which only the sender's own guard can cover.
    always @(negedge clk_i) begin
        if (tx_valid_o) begin
            if (tx_busy_i || prev_valid) proto_viol++;
            tx_q.push_back(tx_data_o);
        end
        if (mem_we_o) begin
            if (prev_we) proto_viol++;
            wr_q.push_back({mem_addr_o, mem_wdata_o});
        end
        prev_valid = tx_valid_o;
        prev_we    = mem_we_o;
        if (busy_cnt > 0) busy_cnt--;
        if (tx_valid_o) busy_cnt = $urandom_range(0, 4);
        tx_busy_i = force_busy || (busy_cnt != 0);
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int exp_len(input int sel);
        if (sel == 0) return 40;
        if (sel == 1) return 57;
        return 4;
    endfunction

    function automatic logic [7:0] exp_byte(input int sel, input int i, input logic [31:0] echo);
        string txt;
        int    len;
        if (sel == 2) return echo[31-8*i -: 8];
        if (sel == 0) txt = "BOOT: SEND SIZE";
        else          txt = "DONE: SEND NEXT ADDR";
        len = exp_len(sel);
        if (i == len - 1) return 8'h0A;
        if (i < txt.len()) return txt[i];
        return 8'h20;
    endfunction

    task automatic wait_tx(input string name, input int n);
        int waited = 0;
        while (tx_q.size() < n && waited < 20000) begin
            @(negedge clk_i);
            waited++;
        end
        if (tx_q.size() < n) check({name, " timeout"}, tx_q.size(), n);
    endtask

    task automatic expect_msg(input string name, input int sel, input logic [31:0] echo);
        int len, got, mism;
        len = exp_len(sel);
        wait_tx(name, len);
        got  = (tx_q.size() >= len) ? len : tx_q.size();
        mism = 0;
        for (int i = 0; i < got; i++) begin
            if (tx_q.pop_front() !== exp_byte(sel, i, echo)) mism++;
        end
        check({name, " length"}, got, len);
        check({name, " bad bytes"}, mism, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk_i);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk_i);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        tx_q.delete();
        wr_q.delete();
        rst_i = 1'b0;
    endtask

    task automatic expect_write(input string name, input logic [31:0] addr, input logic [7:0] data);
        check({name, " count"}, wr_q.size(), 1);
        if (wr_q.size() > 0) check(name, wr_q.pop_front(), {addr, data});
    endtask

    typedef struct {
        logic [7:0]  din;
        logic [31:0] exp_addr;
        logic [7:0]  exp_data;
    } wr_vec_t;

    wr_vec_t vecs[6];

    initial begin
        int          n0;
        logic [31:0] base, size, nxt;
        logic [39:0] model_q[$];
        logic [7:0]  p;
        int          nreg, mism, got_n;

        vecs[0] = '{8'hDD, 32'h0000_0003, 8'hDD};
        vecs[1] = '{8'hCC, 32'h0000_0002, 8'hCC};
        vecs[2] = '{8'hBB, 32'h0000_0001, 8'hBB};
        vecs[3] = '{8'hAA, 32'h0000_0000, 8'hAA};
        vecs[4] = '{8'h11, 32'h0000_1001, 8'h11};
        vecs[5] = '{8'h22, 32'h0000_1000, 8'h22};

        // Reset values
        repeat (3) @(negedge clk_i);
        check("rst core_rst_o", core_rst_o, 1);
        check("rst boot_done_o", boot_done_o, 0);
        check("rst tx_valid_o", tx_valid_o, 0);
        check("rst tx_data_o", tx_data_o, 0);
        check("rst mem_we_o", mem_we_o, 0);
        check("rst mem_addr_o", mem_addr_o, 0);
        check("rst mem_wdata_o", mem_wdata_o, 0);

        // Dummy session with 1000-cycle back-pressure mid-prompt
        do_reset();
        wait_tx("bp start", 10);
        force_busy = 1'b1;
        repeat (3) @(negedge clk_i);
        n0 = tx_q.size();
        repeat (1000) @(negedge clk_i);
        check("bp no tx while busy", tx_q.size(), n0);
        force_busy = 1'b0;
        expect_msg("dummy init", 0, 0);
        send_word(32'h0);
        expect_msg("dummy echo", 2, 32'h0);
        expect_msg("dummy done", 1, 0);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        check("core held before last addr byte", core_rst_o, 1);
        send_byte(8'h00);
        check("dummy core_rst_o released", core_rst_o, 0);
        check("dummy boot_done_o", boot_done_o, 1);
        check("dummy no writes", wr_q.size(), 0);
        send_byte(8'hA5);
        repeat (20) @(negedge clk_i);
        check("finish ignores rx tx count", tx_q.size(), 0);
        check("finish sticky boot_done_o", boot_done_o, 1);
        check("finish ignores rx writes", wr_q.size(), 0);

        // Single region then second region at 0x1000, spurious rx in prompt
        do_reset();
        wait_tx("spurious start", 5);
        send_byte(8'h55);
        expect_msg("r1 init", 0, 0);
        send_word(32'd4);
        expect_msg("r1 echo", 2, 32'd4);
        for (int i = 0; i < 4; i++) begin
            send_byte(vecs[i].din);
            expect_write($sformatf("vec%0d write", i), vecs[i].exp_addr, vecs[i].exp_data);
        end
        expect_msg("r1 done", 1, 0);
        send_word(32'h0000_1000);
        expect_msg("r2 init", 0, 0);
        send_word(32'd2);
        expect_msg("r2 echo", 2, 32'd2);
        for (int i = 4; i < 6; i++) begin
            send_byte(vecs[i].din);
            expect_write($sformatf("vec%0d write", i), vecs[i].exp_addr, vecs[i].exp_data);
        end
        expect_msg("r2 done", 1, 0);
        send_word(32'h0);
        check("r2 boot_done_o", boot_done_o, 1);
        check("r2 no extra writes", wr_q.size(), 0);

        // Reset in the middle of RECV_DATA, region previously moved to 0x2000
        do_reset();
        expect_msg("rr init", 0, 0);
        send_word(32'd1);
        expect_msg("rr echo1", 2, 32'd1);
        send_byte(8'h99);
        expect_write("rr first write", 32'h0, 8'h99);
        expect_msg("rr done", 1, 0);
        send_word(32'h0000_2000);
        expect_msg("rr init2", 0, 0);
        send_word(32'd4);
        expect_msg("rr echo4", 2, 32'd4);
        send_byte(8'h01);
        expect_write("rr write a", 32'h2003, 8'h01);
        send_byte(8'h02);
        expect_write("rr write b", 32'h2002, 8'h02);
        @(negedge clk_i);
        rx_data_i  = 8'h03;
        rx_valid_i = 1'b1;
        #2 rst_i = 1'b1;
        #1;
        check("rr async mem_we_o", mem_we_o, 0);
        check("rr async core_rst_o", core_rst_o, 1);
        check("rr async tx_valid_o", tx_valid_o, 0);
        check("rr async mem_addr_o", mem_addr_o, 0);
        @(negedge clk_i);
        rx_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rr aborted write", wr_q.size(), 0);
        tx_q.delete();
        rst_i = 1'b0;
        expect_msg("rr restart init", 0, 0);
        check("rr no writes before size", wr_q.size(), 0);
        send_word(32'd1);
        expect_msg("rr echo new", 2, 32'd1);
        send_byte(8'h77);
        expect_write("rr region reset", START_ADDR, 8'h77);
        expect_msg("rr done2", 1, 0);
        send_word(32'h0);
        check("rr boot_done_o", boot_done_o, 1);

        // Randomized sessions against the region/offset model
        for (int s = 0; s < 4; s++) begin
            do_reset();
            base = START_ADDR;
            nreg = $urandom_range(1, 3);
            for (int r = 0; r < nreg; r++) begin
                expect_msg($sformatf("rnd%0d.%0d init", s, r), 0, 0);
                size = $urandom_range(0, 6);
                send_word(size);
                expect_msg($sformatf("rnd%0d.%0d echo", s, r), 2, size);
                model_q.delete();
                for (int k = 0; k < int'(size); k++) begin
                    p = 8'($urandom);
                    model_q.push_back({base + size - 1 - k, p});
                    send_byte(p);
                end
                got_n = wr_q.size();
                mism  = 0;
                for (int k = 0; k < model_q.size(); k++) begin
                    if (wr_q.size() == 0 || wr_q.pop_front() !== model_q[k]) mism++;
                end
                check($sformatf("rnd%0d.%0d write count", s, r), got_n, model_q.size());
                check($sformatf("rnd%0d.%0d write data", s, r), mism, 0);
                expect_msg($sformatf("rnd%0d.%0d done", s, r), 1, 0);
                if (r == nreg - 1)    nxt = 32'h0;
                else if (r[0] == 1'b0) nxt = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
                else                   nxt = $urandom | 32'h0000_0100;
                send_word(nxt);
                base = nxt;
            end
            check($sformatf("rnd%0d boot_done_o", s), boot_done_o, 1);
            check($sformatf("rnd%0d core_rst_o", s), core_rst_o, 0);
        end

        check("tx/mem protocol violations", proto_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
Device-side UART bootloader FSM inside riscv_unit. It is the responder to the host programming sequence. It holds the core in reset and prints a 40-byte prompt. It then takes a 4-byte size, echoes it, and writes the payload bytes into memory. It prints a 57-byte completion message, then takes a 4-byte next-region address. A zero address ends programming and releases the core. It drives and consumes the byte-level handshakes of the existing uart_tx/uart_rx instances.

Parameters:
ADDR_W, 32, width of memory byte address
START_ADDR, 32'h0000_0000, load address of the first region after reset

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
rx_data_i  in  8  byte from uart_rx
rx_valid_i  in  1  one-cycle strobe, rx_data_i valid
tx_busy_i  in  1  uart_tx busy
tx_data_o  out  8  byte to uart_tx
tx_valid_o  out  1  one-cycle send strobe
mem_we_o  out  1  byte write enable
mem_addr_o  out  ADDR_W  byte address
mem_wdata_o  out  8  write byte
core_rst_o  out  1  holds core in reset while 1
boot_done_o  out  1  programming finished (sticky)

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Reset values: tx_valid_o=0, tx_data_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, core_rst_o=1, boot_done_o=0. Reset also sets region address := START_ADDR and state := SEND_INIT.
- Reset mid-operation aborts everything. No partial memory write completes after rst_i rises.
- Multi-byte fields (size, address, echo) are MSB first.
- TX handshake:
  - tx_valid_o pulses for exactly 1 cycle, only when tx_busy_i=0 and no pulse occurred in the previous cycle (1-cycle guard for the busy rise).
  - tx_data_o is stable from the pulse until the next pulse.
- RX: a byte is accepted only in RECV_* states. rx_valid_i in any other state is dropped silently.
- States:
  - SEND_INIT: send INIT_MSG[0..39] in order, then go to RECV_SIZE.
  - RECV_SIZE: shift 4 bytes into size register, then go to ECHO_SIZE.
  - ECHO_SIZE: send the 4 size bytes MSB first.
    - If size==0, go to SEND_DONE.
    - Otherwise load remaining := size, go to RECV_DATA.
  - RECV_DATA: the host sends the payload last byte first.
    - The k-th received byte (k from 0) is written to region_addr + size - 1 - k.
    - mem_we_o pulses 1 cycle, in the cycle after the accepting rx_valid_i, with mem_addr_o/mem_wdata_o registered alongside.
    - remaining decrements per byte. When it reaches 0, go to SEND_DONE.
  - SEND_DONE: send DONE_MSG[0..56], then go to RECV_ADDR.
  - RECV_ADDR: shift 4 bytes.
    - If value==0, go to FINISH.
    - Otherwise region_addr := value, go to SEND_INIT.
  - FINISH: core_rst_o=0, boot_done_o=1. The block stays here until reset; all rx bytes are ignored.
- Arithmetic: address computation wraps modulo 2^ADDR_W. size is 32 bits unsigned; no range check.
- Simultaneous events: rx_valid_i arriving in the same cycle as a state change out of a RECV state is ignored. A new region address takes effect before its first write.

Decomposition:
- Package uart_boot_pkg holds:
  - boot_state_t enum.
  - INIT_MSG_LEN=40, DONE_MSG_LEN=57.
  - INIT_MSG and DONE_MSG as constant byte arrays. ASCII text, last byte 8'h0A, short text padded with spaces before the 8'h0A.
- One natural sub-module: uart_boot_msg_sender. It takes a message select plus start, walks the index, applies the TX guard handshake, and returns done. Both message states and ECHO_SIZE use it, with a 4-byte echo source mux.

Test Plan:
- Dummy session: host receives 40 bytes and sends 00 00 00 00, gets echo 00 00 00 00, then 57 bytes. It sends address 00 00 00 00 -> no mem_we_o pulse; core_rst_o falls and boot_done_o=1 after the last address byte.
- Single region:
  - Size 00 00 00 04; payload sent as DD CC BB AA.
  - Expect writes 0x3:DD, 0x2:CC, 0x1:BB, 0x0:AA, each 1-cycle mem_we_o, then DONE_MSG.
- Two regions: after region 1, host sends address 00 00 10 00 -> INIT_MSG resent. Size 2 with payload 11 22 -> writes 0x1001:11, 0x1000:22; then address 0 finishes.
- Back-pressure: hold tx_busy_i=1 for 1000 cycles mid-prompt -> no tx_valid_o pulses while busy, no byte lost or duplicated. Captured prompt equals INIT_MSG exactly.
- Spurious rx: inject rx_valid_i with 0x55 during SEND_INIT -> ignored; size still parses correctly and no write occurs.
- Reset during RECV_DATA after 2 of 4 bytes:
  - rst_i pulse -> outputs at reset values immediately; INIT_MSG restarts.
  - region_addr = START_ADDR.
  - No further writes until a new size is received.
